// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Channels up to RATIO_W_MAX bits wide share the same ratio type.
package clkdiv_pkg;

  localparam int RATIO_W_MAX = 16;
  typedef logic [RATIO_W_MAX-1:0] ratio_t;

  localparam ratio_t MIN_RATIO = ratio_t'(2);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_e;

  // Number of counter values for which the output is high.
  // Odd ratios round up, or down when the half-cycle extension supplies the rest.
  function automatic ratio_t high_count(input ratio_t ratio, input logic duty50);
    ratio_t half;
    half = ratio >> 1;
    return (duty50 || !ratio[0]) ? half : ratio - half;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/shadow ratio, registered div/tick outputs.
// CLKDIV_ODD_DUTY50_EN adds a negedge stage giving 50% duty on odd ratios.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int               DIV_W     = 8,
  parameter logic [DIV_W-1:0] RST_RATIO = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_ratio,
  output logic             pending,
  output logic             div,
  output logic             tick
);

`ifdef CLKDIV_ODD_DUTY50_EN
  localparam logic DUTY50 = 1'b1;
`else
  localparam logic DUTY50 = 1'b0;
`endif

  ch_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] ratio_q, ratio_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             pend_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             wrap;
  ratio_t           h;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ratio_d  = ratio_q;
    shadow_d = shadow_q;
    pend_d   = pending;
    wrap     = (cnt_q == ratio_q - DIV_W'(1));
    case (state_q)
      IDLE: begin
        if (pending) begin
          ratio_d = shadow_q;
          pend_d  = 1'b0;
        end
        if (en) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (wrap) begin
          cnt_d = '0;
          if (pending) begin
            ratio_d = shadow_q;
            pend_d  = 1'b0;
          end
          if (!en) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A write never coincides with a pending apply: it is only accepted when nothing is pending.
    if (wr) begin
      shadow_d = wr_ratio;
      pend_d   = 1'b1;
    end
    h      = high_count(ratio_t'(ratio_d), DUTY50);
    out_d  = (state_d == RUN) && (ratio_t'(cnt_d) < h);
    tick_d = (state_d == RUN) && (cnt_d == ratio_d - DIV_W'(1));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ratio_q  <= RST_RATIO;
      shadow_q <= RST_RATIO;
      pending  <= 1'b0;
      out_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ratio_q  <= ratio_d;
      shadow_q <= shadow_d;
      pending  <= pend_d;
      out_q    <= out_d;
      tick_q   <= tick_d;
    end
  end

`ifdef CLKDIV_ODD_DUTY50_EN
  logic out_n;

  // Half-cycle delayed copy stretches the odd-ratio high phase by half a clk.
  always_ff @(negedge clk or negedge resetn) begin
    if (!resetn) out_n <= 1'b0;
    else         out_n <= out_q;
  end

  assign div = out_q | (out_n & ratio_q[0]);
`else
  assign div = out_q;
`endif

  assign tick = tick_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel runtime-programmable clock divider: config decode and channel array.
// Define CLKDIV_ODD_DUTY50_EN for exact 50% duty on odd ratios.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int                            NUM_CH        = 3,
  parameter int                            DIV_W         = 8,
  parameter logic [NUM_CH-1:0][DIV_W-1:0] DEFAULT_RATIO = {8'd6, 8'd4, 8'd2},
  localparam int                           CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_ratio,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] div_o,
  output logic [NUM_CH-1:0] tick_o
);

  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] wr;
  logic              ch_ok;
  logic              ratio_ok;
  logic              xfer;

  assign ch_ok    = int'(cfg_ch) < NUM_CH;
  assign ratio_ok = cfg_ratio >= DIV_W'(MIN_RATIO);
  // Out-of-range channels select nothing, so they are always ready.
  assign cfg_ready = !(|(sel & pending));
  assign xfer      = cfg_valid && cfg_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign sel[g] = (cfg_ch == CH_W'(g));
    assign wr[g]  = xfer && sel[g] && ratio_ok;

    clkdiv_channel #(
      .DIV_W    (DIV_W),
      .RST_RATIO(DEFAULT_RATIO[g])
    ) u_ch (
      .clk     (clk),
      .resetn  (resetn),
      .en      (en[g]),
      .wr      (wr[g]),
      .wr_ratio(cfg_ratio),
      .pending (pending[g]),
      .div     (div_o[g]),
      .tick    (tick_o[g])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cfg_err <= 1'b0;
    else         cfg_err <= xfer && !(ch_ok && ratio_ok);
  end

endmodule
